// File: rtl/calendar_pkg.sv
// Shared widths, month constants and the month-length helper for the calendar date counter.
package calendar_pkg;

    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int WDAY_W = 3;

    localparam logic [MON_W-1:0] JAN = 4'd1;
    localparam logic [MON_W-1:0] FEB = 4'd2;
    localparam logic [MON_W-1:0] MAR = 4'd3;
    localparam logic [MON_W-1:0] APR = 4'd4;
    localparam logic [MON_W-1:0] MAY = 4'd5;
    localparam logic [MON_W-1:0] JUN = 4'd6;
    localparam logic [MON_W-1:0] JUL = 4'd7;
    localparam logic [MON_W-1:0] AUG = 4'd8;
    localparam logic [MON_W-1:0] SEP = 4'd9;
    localparam logic [MON_W-1:0] OCT = 4'd10;
    localparam logic [MON_W-1:0] NOV = 4'd11;
    localparam logic [MON_W-1:0] DEC = 4'd12;

    // Out-of-range months fall into the 31-day default; they never occur in a held date.
    function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] m,
                                                       input logic is_leap);
        case (m)
            APR, JUN, SEP, NOV: return 5'd30;
            FEB:                return is_leap ? 5'd29 : 5'd28;
            default:            return 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/calendar_leap_calc.sv
// Purely combinational leap-year decision: divisible-by-4 (LEAP_MODE 0) or Gregorian (LEAP_MODE 1).
module calendar_leap_calc #(
    parameter int YEAR_W    = 12,
    parameter int LEAP_MODE = 1
) (
    input  logic [YEAR_W-1:0] year,
    output logic              leap
);

    localparam int EXT_W = YEAR_W + 1;

    logic [EXT_W-1:0] year_ext;
    logic             div4;
    logic             div100;
    logic             div400;

    assign year_ext = {1'b0, year};
    assign div4     = (year_ext % EXT_W'(4))   == '0;
    assign div100   = (year_ext % EXT_W'(100)) == '0;
    assign div400   = (year_ext % EXT_W'(400)) == '0;

    always_comb begin
        leap = div4;
        if (LEAP_MODE != 0) begin
            leap = (div4 && !div100) || div400;
        end
    end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year counter advanced by a daily tick, with validated loading.
// Optional weekday tracking is enabled by defining CALENDAR_WEEKDAY_EN.
module calendar_date_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W     = 12,
    parameter int YEAR_MIN   = 2000,
    parameter int YEAR_MAX   = 2099,
    parameter int RESET_YEAR = 2000,
    parameter int LEAP_MODE  = 1
) (
    input  logic                day_clk,
    input  logic                rst_n,
    input  logic                day_tick,
    input  logic                load,
    input  logic [DAY_W-1:0]    load_day,
    input  logic [MON_W-1:0]    load_month,
    input  logic [YEAR_W-1:0]   load_year,
`ifdef CALENDAR_WEEKDAY_EN
    input  logic [WDAY_W-1:0]   load_wday,
    output logic [WDAY_W-1:0]   wday,
`endif
    output logic [DAY_W-1:0]    day,
    output logic [MON_W-1:0]    month,
    output logic [YEAR_W-1:0]   year,
    output logic [DAY_W-1:0]    max_day,
    output logic                leap,
    output logic                month_end,
    output logic                year_wrap,
    output logic                load_err
);

    localparam int EXT_W = YEAR_W + 1;

    logic             load_leap;
    logic [DAY_W-1:0] load_max;
    logic             load_ok;

    calendar_leap_calc #(.YEAR_W(YEAR_W), .LEAP_MODE(LEAP_MODE)) u_cur_leap (
        .year (year),
        .leap (leap)
    );

    calendar_leap_calc #(.YEAR_W(YEAR_W), .LEAP_MODE(LEAP_MODE)) u_load_leap (
        .year (load_year),
        .leap (load_leap)
    );

    assign max_day  = days_in_month(month, leap);
    assign load_max = days_in_month(load_month, load_leap);

    always_comb begin
        load_ok = ({1'b0, load_month} >= (MON_W+1)'(JAN))
               && ({1'b0, load_month} <= (MON_W+1)'(DEC))
               && ({1'b0, load_year}  >= EXT_W'(YEAR_MIN))
               && ({1'b0, load_year}  <= EXT_W'(YEAR_MAX))
               && (load_day != '0)
               && ({1'b0, load_day}   <= {1'b0, load_max});
`ifdef CALENDAR_WEEKDAY_EN
        if (load_wday == 3'd7) begin
            load_ok = 1'b0;
        end
`endif
    end

    // A load always takes priority; a tick in the same cycle is dropped even if the load is rejected.
    always_ff @(posedge day_clk) begin
        if (!rst_n) begin
            day       <= 5'd1;
            month     <= JAN;
            year      <= YEAR_W'(RESET_YEAR);
            month_end <= 1'b0;
            year_wrap <= 1'b0;
            load_err  <= 1'b0;
`ifdef CALENDAR_WEEKDAY_EN
            wday      <= 3'd5;
`endif
        end else begin
            month_end <= 1'b0;
            year_wrap <= 1'b0;
            load_err  <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    day   <= load_day;
                    month <= load_month;
                    year  <= load_year;
`ifdef CALENDAR_WEEKDAY_EN
                    wday  <= load_wday;
`endif
                end else begin
                    load_err <= 1'b1;
                end
            end else if (day_tick) begin
`ifdef CALENDAR_WEEKDAY_EN
                wday <= (wday == 3'd6) ? '0 : wday + 1'b1;
`endif
                if ({1'b0, day} < {1'b0, max_day}) begin
                    day <= day + 1'b1;
                end else begin
                    day       <= 5'd1;
                    month_end <= 1'b1;
                    if ({1'b0, month} < (MON_W+1)'(DEC)) begin
                        month <= month + 1'b1;
                    end else begin
                        month <= JAN;
                        if ({1'b0, year} < EXT_W'(YEAR_MAX)) begin
                            year <= year + 1'b1;
                        end else begin
                            year      <= YEAR_W'(YEAR_MIN);
                            year_wrap <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Three differently configured counters driven in lockstep and compared against a calendar model.
// Weekday checks are included when CALENDAR_WEEKDAY_EN is defined.
module tb_calendar_date_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        day_tick = 1'b0;
    logic        load = 1'b0;
    logic [4:0]  ld_day = '0;
    logic [3:0]  ld_month = '0;
    logic [11:0] ld_year = '0;
    logic [2:0]  ld_wday = '0;

    logic [4:0]  day_o   [3];
    logic [3:0]  mon_o   [3];
    logic [11:0] year_o  [3];
    logic [4:0]  max_o   [3];
    logic        leap_o  [3];
    logic        end_o   [3];
    logic        wrap_o  [3];
    logic        err_o   [3];
`ifdef CALENDAR_WEEKDAY_EN
    logic [2:0]  wday_o  [3];
`endif

    int checks = 0;
    int errors = 0;

    // Per-instance configuration mirrored from the instantiations below.
    int y_min[3]   = '{2000, 2000, 2000};
    int y_max[3]   = '{2099, 4000, 4000};
    int y_reset[3] = '{2000, 2000, 2024};
    int l_mode[3]  = '{1, 1, 0};

    int m_day[3], m_mon[3], m_year[3], m_wday[3];
    bit m_end[3], m_wrap[3], m_err[3];

    always #5 clk = ~clk;

    calendar_date_counter #(.YEAR_W(12), .YEAR_MIN(2000), .YEAR_MAX(2099),
                            .RESET_YEAR(2000), .LEAP_MODE(1)) dut0 (
        .day_clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
        .load_day(ld_day), .load_month(ld_month), .load_year(ld_year),
`ifdef CALENDAR_WEEKDAY_EN
        .load_wday(ld_wday), .wday(wday_o[0]),
`endif
        .day(day_o[0]), .month(mon_o[0]), .year(year_o[0]), .max_day(max_o[0]),
        .leap(leap_o[0]), .month_end(end_o[0]), .year_wrap(wrap_o[0]), .load_err(err_o[0])
    );

    calendar_date_counter #(.YEAR_W(12), .YEAR_MIN(2000), .YEAR_MAX(4000),
                            .RESET_YEAR(2000), .LEAP_MODE(1)) dut1 (
        .day_clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
        .load_day(ld_day), .load_month(ld_month), .load_year(ld_year),
`ifdef CALENDAR_WEEKDAY_EN
        .load_wday(ld_wday), .wday(wday_o[1]),
`endif
        .day(day_o[1]), .month(mon_o[1]), .year(year_o[1]), .max_day(max_o[1]),
        .leap(leap_o[1]), .month_end(end_o[1]), .year_wrap(wrap_o[1]), .load_err(err_o[1])
    );

    calendar_date_counter #(.YEAR_W(12), .YEAR_MIN(2000), .YEAR_MAX(4000),
                            .RESET_YEAR(2024), .LEAP_MODE(0)) dut2 (
        .day_clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
        .load_day(ld_day), .load_month(ld_month), .load_year(ld_year),
`ifdef CALENDAR_WEEKDAY_EN
        .load_wday(ld_wday), .wday(wday_o[2]),
`endif
        .day(day_o[2]), .month(mon_o[2]), .year(year_o[2]), .max_day(max_o[2]),
        .leap(leap_o[2]), .month_end(end_o[2]), .year_wrap(wrap_o[2]), .load_err(err_o[2])
    );

    function automatic bit isLeap(input int y, input int mode);
        if (mode == 0) return (y % 4) == 0;
        return ((y % 4) == 0 && (y % 100) != 0) || (y % 400) == 0;
    endfunction

    function automatic int monthLen(input int m, input int y, input int mode);
        int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 31;
        if (m == 2 && isLeap(y, mode)) return 29;
        return lens[m-1];
    endfunction

    function automatic bit loadValid(input int i, input int d, input int m, input int y, input int w);
        bit ok;
        ok = (m >= 1 && m <= 12) && (y >= y_min[i] && y <= y_max[i])
             && (d >= 1 && d <= monthLen(m, y, l_mode[i]));
`ifdef CALENDAR_WEEKDAY_EN
        if (w == 7) ok = 0;
`else
        if (w < 0) ok = 0;
`endif
        return ok;
    endfunction

    task automatic modelStep(input bit rstn, input bit tk, input bit ld,
                             input int d, input int m, input int y, input int w);
        for (int i = 0; i < 3; i++) begin
            m_end[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
            if (!rstn) begin
                m_day[i] = 1; m_mon[i] = 1; m_year[i] = y_reset[i]; m_wday[i] = 5;
            end else if (ld) begin
                if (loadValid(i, d, m, y, w)) begin
                    m_day[i] = d; m_mon[i] = m; m_year[i] = y; m_wday[i] = w;
                end else begin
                    m_err[i] = 1;
                end
            end else if (tk) begin
                m_wday[i] = (m_wday[i] + 1) % 7;
                if (m_day[i] < monthLen(m_mon[i], m_year[i], l_mode[i])) begin
                    m_day[i]++;
                end else begin
                    m_day[i] = 1;
                    m_end[i] = 1;
                    if (m_mon[i] < 12) begin
                        m_mon[i]++;
                    end else begin
                        m_mon[i] = 1;
                        if (m_year[i] < y_max[i]) begin
                            m_year[i]++;
                        end else begin
                            m_year[i] = y_min[i];
                            m_wrap[i] = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic checkField(input string tag, input int idx, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d observed %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 3; i++) begin
            checkField("day",       i, 32'(day_o[i]),  m_day[i]);
            checkField("month",     i, 32'(mon_o[i]),  m_mon[i]);
            checkField("year",      i, 32'(year_o[i]), m_year[i]);
            checkField("max_day",   i, 32'(max_o[i]),  monthLen(m_mon[i], m_year[i], l_mode[i]));
            checkField("leap",      i, 32'(leap_o[i]), int'(isLeap(m_year[i], l_mode[i])));
            checkField("month_end", i, 32'(end_o[i]),  int'(m_end[i]));
            checkField("year_wrap", i, 32'(wrap_o[i]), int'(m_wrap[i]));
            checkField("load_err",  i, 32'(err_o[i]),  int'(m_err[i]));
`ifdef CALENDAR_WEEKDAY_EN
            checkField("wday",      i, 32'(wday_o[i]), m_wday[i]);
`endif
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare 1 time unit later.
    task automatic applyStimulus(input bit rstn, input bit tk, input bit ld,
                                 input int d, input int m, input int y, input int w);
        rst_n    = rstn;
        day_tick = tk;
        load     = ld;
        ld_day   = 5'(d);
        ld_month = 4'(m);
        ld_year  = 12'(y);
        ld_wday  = 3'(w);
        @(posedge clk);
        modelStep(rstn, tk, ld, d, m, y, w);
        #1;
        rst_n    = 1'b1;
        day_tick = 1'b0;
        load     = 1'b0;
        checkOutput();
    endtask

    initial begin
        int d, m, y, w;
        $display("[TB] start");

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        applyStimulus(1, 0, 1, 28, 2, 2024, 2);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);

        applyStimulus(1, 0, 1, 28, 2, 2100, 6);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);

        applyStimulus(1, 0, 1, 31, 12, 2099, 3);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        applyStimulus(1, 0, 1, 30, 2, 2024, 1);
        applyStimulus(1, 0, 1, 31, 4, 2023, 1);
        applyStimulus(1, 0, 1, 15, 13, 2023, 1);
        applyStimulus(1, 0, 1, 0, 5, 2023, 1);
        applyStimulus(1, 0, 1, 10, 5, 1999, 1);
        applyStimulus(1, 0, 1, 10, 5, 2023, 7);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        applyStimulus(1, 1, 1, 10, 6, 2030, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 31, 6, 2030, 0);

        applyStimulus(0, 1, 1, 15, 8, 2050, 2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            d = int'($urandom_range(0, 31));
            m = int'($urandom_range(0, 13));
            y = ($urandom_range(0, 3) == 0) ? 2099 : int'($urandom_range(1995, 2105));
            w = int'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                applyStimulus(1, $urandom_range(0, 1) == 1, 1, d, m, y, w);
            else if ($urandom_range(0, 199) == 0)
                applyStimulus(0, 1, 0, d, m, y, w);
            else
                applyStimulus(1, $urandom_range(0, 3) != 0, 0, d, m, y, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
